// File: rtl/prim_accum.sv
// rtl/prim_accum.sv - framed accumulator: sums a sample stream, emits one result per frame
// Signed/unsigned and saturate/wrap behaviour are fixed at elaboration time.
module prim_accum #(
   parameter int IN_W     = 8,
   parameter int ACC_W    = 32,
   parameter int SIGNED   = 1,
   parameter int SATURATE = 1,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_data,
   output logic             out_ovf,
   output logic [CNT_W-1:0] out_count
);

   typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

   localparam int PAD = ACC_W + 1 - IN_W;

   state_t           state, state_next;
   logic [ACC_W-1:0] acc;
   logic [CNT_W-1:0] cnt;
   logic             ovf;

   logic             accept;
   logic             ext_sign;
   logic [ACC_W:0]   ext_in;
   logic [ACC_W:0]   acc_ext;
   logic [ACC_W:0]   sum;
   logic             beat_ovf;
   logic [ACC_W-1:0] sum_res;
   logic [CNT_W-1:0] cnt_inc;

   assign in_ready  = (state != HOLD);
   assign out_valid = (state == HOLD);
   assign accept    = in_valid && in_ready;

   assign ext_sign = (SIGNED != 0) ? in_data[IN_W-1] : 1'b0;
   assign ext_in   = {{PAD{ext_sign}}, in_data};
   assign acc_ext  = {((SIGNED != 0) ? acc[ACC_W-1] : 1'b0), acc};
   assign sum      = acc_ext + ext_in;
   assign cnt_inc  = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;

   // Both operands fit in ACC_W+1 bits, so the extra top bit tells us the true sign/carry.
   always_comb begin
      beat_ovf = 1'b0;
      sum_res  = sum[ACC_W-1:0];
      if (SIGNED != 0) begin
         beat_ovf = sum[ACC_W] ^ sum[ACC_W-1];
      end else begin
         beat_ovf = sum[ACC_W];
      end
      if (beat_ovf && (SATURATE != 0)) begin
         if (SIGNED != 0) begin
            sum_res = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
         end else begin
            sum_res = {ACC_W{1'b1}};
         end
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE, ACCUM: begin
            if (accept) begin
               state_next = in_last ? HOLD : ACCUM;
            end
         end
         HOLD: begin
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         acc       <= '0;
         cnt       <= '0;
         ovf       <= 1'b0;
         out_data  <= '0;
         out_ovf   <= 1'b0;
         out_count <= '0;
      end else begin
         state <= state_next;
         if (accept) begin
            if (in_last) begin
               out_data  <= sum_res;
               out_count <= cnt_inc;
               out_ovf   <= ovf | beat_ovf;
               acc       <= '0;
               cnt       <= '0;
               ovf       <= 1'b0;
            end else begin
               acc <= sum_res;
               cnt <= cnt_inc;
               ovf <= ovf | beat_ovf;
            end
         end
      end
   end

endmodule

// File: tb/tb_prim_accum.sv
// tb/tb_prim_accum.sv - self-checking bench for prim_accum
// Four instances share one stimulus stream; each covers a different parameter set.
module tb_prim_accum;

   logic clk;
   logic rst;
   logic in_valid;
   logic [7:0] in_data;
   logic in_last;
   logic out_ready;

   logic        in_ready_0, in_ready_1, in_ready_2, in_ready_3;
   logic        out_valid_0, out_valid_1, out_valid_2, out_valid_3;
   logic        out_ovf_0, out_ovf_1, out_ovf_2, out_ovf_3;
   logic [31:0] out_data_0;
   logic [9:0]  out_data_1;
   logic [9:0]  out_data_2;
   logic [11:0] out_data_3;
   logic [15:0] out_count_0, out_count_1, out_count_2;
   logic [3:0]  out_count_3;

   logic [3:0]        ov, ir, oo;
   logic [3:0][63:0]  od;
   logic [3:0][15:0]  oc;

   assign ov = {out_valid_3, out_valid_2, out_valid_1, out_valid_0};
   assign ir = {in_ready_3, in_ready_2, in_ready_1, in_ready_0};
   assign oo = {out_ovf_3, out_ovf_2, out_ovf_1, out_ovf_0};
   assign od[0] = {32'd0, out_data_0};
   assign od[1] = {54'd0, out_data_1};
   assign od[2] = {54'd0, out_data_2};
   assign od[3] = {52'd0, out_data_3};
   assign oc[0] = out_count_0;
   assign oc[1] = out_count_1;
   assign oc[2] = out_count_2;
   assign oc[3] = {12'd0, out_count_3};

   prim_accum #(.IN_W(8), .ACC_W(32), .SIGNED(1), .SATURATE(1), .CNT_W(16)) u_s32 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_0), .in_data(in_data),
      .in_last(in_last), .out_valid(out_valid_0), .out_ready(out_ready), .out_data(out_data_0),
      .out_ovf(out_ovf_0), .out_count(out_count_0));
   prim_accum #(.IN_W(8), .ACC_W(10), .SIGNED(1), .SATURATE(1), .CNT_W(16)) u_s10_sat (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_1), .in_data(in_data),
      .in_last(in_last), .out_valid(out_valid_1), .out_ready(out_ready), .out_data(out_data_1),
      .out_ovf(out_ovf_1), .out_count(out_count_1));
   prim_accum #(.IN_W(8), .ACC_W(10), .SIGNED(1), .SATURATE(0), .CNT_W(16)) u_s10_wrap (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_2), .in_data(in_data),
      .in_last(in_last), .out_valid(out_valid_2), .out_ready(out_ready), .out_data(out_data_2),
      .out_ovf(out_ovf_2), .out_count(out_count_2));
   prim_accum #(.IN_W(8), .ACC_W(12), .SIGNED(0), .SATURATE(1), .CNT_W(4)) u_u12_sat (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_3), .in_data(in_data),
      .in_last(in_last), .out_valid(out_valid_3), .out_ready(out_ready), .out_data(out_data_3),
      .out_ovf(out_ovf_3), .out_count(out_count_3));

   typedef struct packed {
      logic [3:0][63:0] data;
      logic [3:0]       ovf;
      logic [3:0][15:0] cnt;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference arithmetic on 64-bit integers, independent of bit-level tricks.
   task automatic push_expected(input logic [7:0] smp[$]);
      exp_t   e;
      longint acc, t, s, mx, mn;
      int     w, cw, n, cmax;
      bit     sg, st;
      e = '0;
      for (int k = 0; k < 4; k++) begin
         w  = (k == 0) ? 32 : (k == 3) ? 12 : 10;
         sg = (k != 3);
         st = (k != 2);
         cw = (k == 3) ? 4 : 16;
         if (sg) begin
            mx = (64'sd1 <<< (w - 1)) - 1;
            mn = -(64'sd1 <<< (w - 1));
         end else begin
            mx = (64'sd1 <<< w) - 1;
            mn = 0;
         end
         acc = 0;
         foreach (smp[i]) begin
            s = sg ? longint'($signed(smp[i])) : longint'({56'd0, smp[i]});
            t = acc + s;
            if (t > mx) begin
               e.ovf[k] = 1'b1;
               t = st ? mx : t - (64'sd1 <<< w);
            end else if (t < mn) begin
               e.ovf[k] = 1'b1;
               t = st ? mn : t + (64'sd1 <<< w);
            end
            acc = t;
         end
         e.data[k] = 64'(acc) & ((64'd1 << w) - 64'd1);
         n    = smp.size();
         cmax = (1 << cw) - 1;
         e.cnt[k] = 16'((n > cmax) ? cmax : n);
      end
      sb.push_back(e);
   endtask

   task automatic send_beat(input logic [7:0] d, input logic l);
      int guard = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      while (!in_ready_0 && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      n_cmp++;
      if (!in_ready_0) begin
         n_bad++;
         $display("FAIL send_beat: in_ready=%0b after %0d cycles, required 1", in_ready_0, guard);
      end
      @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] smp[$]);
      push_expected(smp);
      foreach (smp[i]) send_beat(smp[i], (i == smp.size() - 1));
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic pop_check(input string name);
      exp_t e;
      int   guard = 0;
      while (!out_valid_0 && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      n_cmp++;
      if (!out_valid_0) begin
         n_bad++;
         $display("FAIL %s out_valid timeout: got 0, required 1", name);
         return;
      end
      n_cmp++;
      if (sb.size() == 0) begin
         n_bad++;
         $display("FAIL %s unexpected result: scoreboard size 0, required >0", name);
         return;
      end
      e = sb.pop_front();
      for (int k = 0; k < 4; k++) begin
         n_cmp++;
         if (ov[k] !== 1'b1) begin
            n_bad++;
            $display("FAIL %s[%0d] out_valid: got %0b, required 1", name, k, ov[k]);
         end
         n_cmp++;
         if (od[k] !== e.data[k]) begin
            n_bad++;
            $display("FAIL %s[%0d] out_data: got %0h, required %0h", name, k, od[k], e.data[k]);
         end
         n_cmp++;
         if (oo[k] !== e.ovf[k]) begin
            n_bad++;
            $display("FAIL %s[%0d] out_ovf: got %0b, required %0b", name, k, oo[k], e.ovf[k]);
         end
         n_cmp++;
         if (oc[k] !== e.cnt[k]) begin
            n_bad++;
            $display("FAIL %s[%0d] out_count: got %0d, required %0d", name, k, oc[k], e.cnt[k]);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_valid = 1'b1;
      in_data = 8'h55;
      in_last = 1'b1;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         n_cmp++;
         if (ov[k] !== 1'b0 || od[k] !== 64'd0 || oo[k] !== 1'b0 || oc[k] !== 16'd0 || ir[k] !== 1'b1) begin
            n_bad++;
            $display("FAIL reset[%0d]: valid=%0b data=%0h ovf=%0b count=%0d ready=%0b, required 0/0/0/0/1",
                     k, ov[k], od[k], oo[k], oc[k], ir[k]);
         end
      end
      in_valid = 1'b0;
      in_last = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (in_ready_0 !== 1'b1 || out_valid_0 !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_release: ready=%0b valid=%0b, required 1/0", in_ready_0, out_valid_0);
      end
   endtask

   task automatic test_signed_frame();
      logic [7:0] f[$];
      f = {8'd5, 8'hFD, 8'd100, 8'h80};
      out_ready = 1'b1;
      send_frame(f);
      n_cmp++;
      if (out_valid_0 !== 1'b1 || out_data_0 !== 32'hFFFFFFE6 || out_count_0 !== 16'd4 || out_ovf_0 !== 1'b0) begin
         n_bad++;
         $display("FAIL signed_frame: valid=%0b data=%0h count=%0d ovf=%0b, required 1/ffffffe6/4/0",
                  out_valid_0, out_data_0, out_count_0, out_ovf_0);
      end
      n_cmp++;
      if (in_ready_0 !== 1'b0) begin
         n_bad++;
         $display("FAIL signed_frame in_ready in HOLD: got %0b, required 0", in_ready_0);
      end
      pop_check("signed_frame");
      @(negedge clk);
      n_cmp++;
      if (in_ready_0 !== 1'b1 || out_valid_0 !== 1'b0) begin
         n_bad++;
         $display("FAIL signed_frame after: ready=%0b valid=%0b, required 1/0", in_ready_0, out_valid_0);
      end
   endtask

   task automatic test_sat_wrap();
      logic [7:0] f[$];
      f = {8'd127, 8'd127, 8'd127, 8'd127, 8'd127};
      out_ready = 1'b1;
      send_frame(f);
      n_cmp++;
      if (out_data_1 !== 10'd511 || out_ovf_1 !== 1'b1 || out_count_1 !== 16'd5) begin
         n_bad++;
         $display("FAIL sat10: data=%0d ovf=%0b count=%0d, required 511/1/5", out_data_1, out_ovf_1, out_count_1);
      end
      n_cmp++;
      if (out_data_2 !== 10'h27B || out_ovf_2 !== 1'b1) begin
         n_bad++;
         $display("FAIL wrap10: data=%0h ovf=%0b, required 27b/1", out_data_2, out_ovf_2);
      end
      pop_check("sat_wrap");
      @(negedge clk);
   endtask

   task automatic test_unsigned();
      logic [7:0] f[$];
      f = {};
      for (int i = 0; i < 17; i++) f.push_back(8'hFF);
      out_ready = 1'b1;
      send_frame(f);
      n_cmp++;
      if (out_data_3 !== 12'hFFF || out_ovf_3 !== 1'b1 || out_count_3 !== 4'hF) begin
         n_bad++;
         $display("FAIL unsigned_sat: data=%0h ovf=%0b count=%0d, required fff/1/15", out_data_3, out_ovf_3, out_count_3);
      end
      pop_check("unsigned_sat");
      @(negedge clk);
      f = {8'h80};
      send_frame(f);
      n_cmp++;
      if (out_data_3 !== 12'd128 || out_data_0 !== 32'hFFFFFF80) begin
         n_bad++;
         $display("FAIL ext_0x80: unsigned=%0h signed=%0h, required 080/ffffff80", out_data_3, out_data_0);
      end
      pop_check("ext_0x80");
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      logic [7:0] f[$];
      f = {8'd1, 8'd2};
      out_ready = 1'b0;
      send_frame(f);
      pop_check("bp_first");
      in_valid = 1'b1;
      in_data = 8'd9;
      in_last = 1'b1;
      for (int c = 0; c < 10; c++) begin
         n_cmp++;
         if (in_ready_0 !== 1'b0 || out_valid_0 !== 1'b1 || out_data_0 !== 32'd3 ||
             out_count_0 !== 16'd2 || out_ovf_0 !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_hold cycle %0d: ready=%0b valid=%0b data=%0h count=%0d ovf=%0b, required 0/1/3/2/0",
                     c, in_ready_0, out_valid_0, out_data_0, out_count_0, out_ovf_0);
         end
         @(negedge clk);
      end
      f = {8'd9};
      push_expected(f);
      out_ready = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (out_valid_0 !== 1'b0 || in_ready_0 !== 1'b1) begin
         n_bad++;
         $display("FAIL bp_release: valid=%0b ready=%0b, required 0/1", out_valid_0, in_ready_0);
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_last = 1'b0;
      n_cmp++;
      if (out_data_0 !== 32'd9 || out_count_0 !== 16'd1) begin
         n_bad++;
         $display("FAIL bp_next_frame: data=%0h count=%0d, required 9/1", out_data_0, out_count_0);
      end
      pop_check("bp_next_frame");
      @(negedge clk);
   endtask

   task automatic test_single_and_abort();
      logic [7:0] f[$];
      out_ready = 1'b1;
      f = {8'hFF};
      send_frame(f);
      n_cmp++;
      if (out_data_0 !== 32'hFFFFFFFF || out_count_0 !== 16'd1) begin
         n_bad++;
         $display("FAIL single_beat: data=%0h count=%0d, required ffffffff/1", out_data_0, out_count_0);
      end
      pop_check("single_beat");
      @(negedge clk);
      send_beat(8'd1, 1'b0);
      send_beat(8'd2, 1'b0);
      rst = 1'b1;
      in_valid = 1'b0;
      #1;
      n_cmp++;
      if (out_valid_0 !== 1'b0 || in_ready_0 !== 1'b1) begin
         n_bad++;
         $display("FAIL abort_reset: valid=%0b ready=%0b, required 0/1", out_valid_0, in_ready_0);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_cmp++;
         if (out_valid_0 !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_no_output cycle %0d: valid=%0b, required 0", c, out_valid_0);
         end
      end
      f = {8'd2, 8'd3};
      send_frame(f);
      n_cmp++;
      if (out_data_0 !== 32'd5 || out_count_0 !== 16'd2 || out_ovf_0 !== 1'b0) begin
         n_bad++;
         $display("FAIL after_abort: data=%0h count=%0d ovf=%0b, required 5/2/0", out_data_0, out_count_0, out_ovf_0);
      end
      pop_check("after_abort");
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_signed_frame();
      test_sat_wrap();
      test_unsigned();
      test_backpressure();
      test_single_and_abort();
      n_cmp++;
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_drain: %0d results outstanding, required 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
